// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle sequencer: opcodes, state
// encodings, mux select codes and an opcode classifier.
package multicycle_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned CNT_W = 16;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd7
  } state_e;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_TARGET = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_SUB   = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
  } inst_class_t;

  // One-hot instruction class; all-zero means the opcode is not supported.
  function automatic inst_class_t classify(input logic [OPC_W-1:0] opcode);
    inst_class_t c;
    c        = '0;
    c.r      = (opcode == OP_R);
    c.i      = (opcode == OP_I);
    c.load   = (opcode == OP_LOAD);
    c.store  = (opcode == OP_STORE);
    c.branch = (opcode == OP_BRANCH);
    c.jal    = (opcode == OP_JAL);
    c.jalr   = (opcode == OP_JALR);
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake between the sequencer and the memories.
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ready;
  logic            dmem_read;
  logic            dmem_write;
  logic            dmem_ready;

  modport master (
    output imem_req, dmem_read, dmem_write,
    input  imem_rdata, imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_read, dmem_write,
    output imem_rdata, imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_branch_cond.sv
// Branch resolution: funct3 plus ALU flags -> taken, and whether funct3 is a
// defined branch condition.
module multicycle_ctrl_branch_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken_c,
  output logic       valid_c
);

  always_comb begin
    taken_c = 1'b0;
    valid_c = 1'b1;
    case (funct3)
      3'b000:  taken_c = zero;
      3'b001:  taken_c = !zero;
      3'b100:  taken_c = lt;
      3'b101:  taken_c = !lt;
      3'b110:  taken_c = ltu;
      3'b111:  taken_c = !ltu;
      default: valid_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory wait
// handshakes, timeout-to-halt and a retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  multicycle_ctrl_if.master   mem,
  input  logic                alu_zero,
  input  logic                alu_lt,
  input  logic                alu_ltu,
  output logic [XLEN-1:0]     ir,
  output logic                pc_write,
  output logic [1:0]          pc_sel,
  output logic                reg_write,
  output logic                alu_src_imm,
  output logic [1:0]          alu_op,
  output logic [1:0]          wb_sel,
  output logic [2:0]          state,
  output logic                halted,
  output logic                bus_err,
  output logic [XLEN-1:0]     instret
);

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  state_e           state_q;
  state_e           seq_next_c;
  logic [CNT_W-1:0] wait_cnt;
  logic             stop_pend;
  inst_class_t      cls;
  logic             br_taken;
  logic             br_valid;
  logic             imem_req_c;
  logic             dmem_read_c;
  logic             dmem_write_c;

  assign state = state_q;
  assign cls   = classify(ir[OPC_W-1:0]);

  // A run drop anywhere in the instruction is remembered so it parks in IDLE.
  assign seq_next_c = (run && !stop_pend) ? ST_FETCH : ST_IDLE;

  multicycle_ctrl_branch_cond u_branch_cond (
    .funct3  (ir[14:12]),
    .zero    (alu_zero),
    .lt      (alu_lt),
    .ltu     (alu_ltu),
    .taken_c (br_taken),
    .valid_c (br_valid)
  );

  // Strobes decoded from state and ir; forced low while reset is asserted.
  always_comb begin
    imem_req_c   = 1'b0;
    dmem_read_c  = 1'b0;
    dmem_write_c = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = PC_SEL_PLUS4;
    reg_write    = 1'b0;
    alu_src_imm  = 1'b0;
    alu_op       = ALU_OP_ADD;
    wb_sel       = WB_SEL_ALU;
    if (rst) begin
      case (state_q)
        ST_FETCH: imem_req_c = 1'b1;
        ST_EXEC: begin
          alu_src_imm = cls.i | cls.load | cls.store | cls.jalr;
          if (cls.r || cls.i)   alu_op = ALU_OP_FUNCT;
          else if (cls.branch)  alu_op = ALU_OP_SUB;
          if (cls.branch && br_valid) begin
            pc_write = 1'b1;
            pc_sel   = br_taken ? PC_SEL_TARGET : PC_SEL_PLUS4;
          end
        end
        ST_MEM: begin
          dmem_read_c  = cls.load;
          dmem_write_c = cls.store;
          pc_write     = cls.store & mem.dmem_ready;
        end
        ST_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          if (cls.load)                wb_sel = WB_SEL_MEM;
          else if (cls.jal || cls.jalr) wb_sel = WB_SEL_PC4;
          if (cls.jal)       pc_sel = PC_SEL_TARGET;
          else if (cls.jalr) pc_sel = PC_SEL_JALR;
        end
        default: ;
      endcase
    end
  end

  assign mem.imem_req   = imem_req_c;
  assign mem.dmem_read  = dmem_read_c;
  assign mem.dmem_write = dmem_write_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ir        <= '0;
      instret   <= '0;
      halted    <= 1'b0;
      bus_err   <= 1'b0;
      wait_cnt  <= '0;
      stop_pend <= 1'b0;
    end else begin
      // Every retirement is also the cycle that updates the PC.
      if (pc_write) instret <= instret + XLEN'(1);
      if (!run && state_q != ST_IDLE) stop_pend <= 1'b1;
      if (state_q != ST_FETCH && state_q != ST_MEM) wait_cnt <= '0;

      case (state_q)
        ST_IDLE: begin
          stop_pend <= 1'b0;
          if (run) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (mem.imem_ready) begin
            ir       <= mem.imem_rdata;
            wait_cnt <= '0;
            state_q  <= ST_DECODE;
          end else if (wait_cnt == TIMEOUT) begin
            bus_err  <= 1'b1;
            state_q  <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DECODE: begin
          if (|cls) begin
            state_q <= ST_EXEC;
          end else begin
            halted  <= 1'b1;
            state_q <= ST_HALT;
          end
        end
        ST_EXEC: begin
          if (cls.branch) begin
            if (br_valid) begin
              state_q <= seq_next_c;
            end else begin
              halted  <= 1'b1;
              state_q <= ST_HALT;
            end
          end else if (cls.load || cls.store) begin
            state_q <= ST_MEM;
          end else begin
            state_q <= ST_WB;
          end
        end
        ST_MEM: begin
          if (mem.dmem_ready) begin
            wait_cnt <= '0;
            state_q  <= cls.load ? ST_WB : seq_next_c;
          end else if (wait_cnt == TIMEOUT) begin
            bus_err  <= 1'b1;
            state_q  <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_WB:   state_q <= seq_next_c;
        ST_HALT: ;
        default: state_q <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: directed and random instructions compared cycle by
// cycle against an instruction-level timing model.
module tb_multicycle_ctrl;

  localparam int unsigned TMO = 4;

  localparam logic [6:0] K_R   = 7'b0110011;
  localparam logic [6:0] K_I   = 7'b0010011;
  localparam logic [6:0] K_LD  = 7'b0000011;
  localparam logic [6:0] K_ST  = 7'b0100011;
  localparam logic [6:0] K_BR  = 7'b1100011;
  localparam logic [6:0] K_JAL = 7'b1101111;
  localparam logic [6:0] K_JR  = 7'b1100111;

  typedef struct packed {
    logic [2:0] st;
    logic       run;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       reg_write;
    logic       dmem_read;
    logic       dmem_write;
    logic       alu_src_imm;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
  } step_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        alu_zero = 1'b0;
  logic        alu_lt = 1'b0;
  logic        alu_ltu = 1'b0;
  logic [31:0] ir;
  logic        pc_write;
  logic [1:0]  pc_sel;
  logic        reg_write;
  logic        alu_src_imm;
  logic [1:0]  alu_op;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        halted;
  logic        bus_err;
  logic [31:0] instret;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] exp_instret = '0;
  bit          model_idle = 1'b1;
  step_t       trace[$];

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .mem         (bus),
    .alu_zero    (alu_zero),
    .alu_lt      (alu_lt),
    .alu_ltu     (alu_ltu),
    .ir          (ir),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .reg_write   (reg_write),
    .alu_src_imm (alu_src_imm),
    .alu_op      (alu_op),
    .wb_sel      (wb_sel),
    .state       (state),
    .halted      (halted),
    .bus_err     (bus_err),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input string what, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  function automatic step_t blank(input logic [2:0] st);
    step_t s;
    s     = '0;
    s.st  = st;
    s.run = 1'b1;
    return s;
  endfunction

  // Expected cycle-by-cycle behaviour of one legal instruction.
  function automatic void build(input logic [31:0] instr, input int iwait, input int dwait);
    step_t      s;
    logic [6:0] op = instr[6:0];
    logic [2:0] f3 = instr[14:12];
    logic       cond;
    trace.delete();
    for (int k = 0; k <= iwait; k++) begin
      s = blank(3'd1);
      s.imem_req   = 1'b1;
      s.imem_ready = (k == iwait);
      trace.push_back(s);
    end
    trace.push_back(blank(3'd2));
    s = blank(3'd3);
    s.alu_src_imm = (op == K_I) || (op == K_LD) || (op == K_ST) || (op == K_JR);
    s.alu_op = (op == K_R || op == K_I) ? 2'd2 : (op == K_BR) ? 2'd1 : 2'd0;
    if (op == K_BR) begin
      cond       = (f3[2] ? (f3[1] ? alu_ltu : alu_lt) : alu_zero) ^ f3[0];
      s.pc_write = 1'b1;
      s.pc_sel   = cond ? 2'd1 : 2'd0;
    end
    trace.push_back(s);
    if (op == K_LD || op == K_ST) begin
      for (int k = 0; k <= dwait; k++) begin
        s = blank(3'd4);
        s.dmem_read  = (op == K_LD);
        s.dmem_write = (op == K_ST);
        s.dmem_ready = (k == dwait);
        s.pc_write   = (op == K_ST) && (k == dwait);
        trace.push_back(s);
      end
    end
    if (op != K_BR && op != K_ST) begin
      s = blank(3'd5);
      s.reg_write = 1'b1;
      s.pc_write  = 1'b1;
      s.wb_sel    = (op == K_LD) ? 2'd1 : (op == K_JAL || op == K_JR) ? 2'd2 : 2'd0;
      s.pc_sel    = (op == K_JAL) ? 2'd1 : (op == K_JR) ? 2'd2 : 2'd0;
      trace.push_back(s);
    end
  endfunction

  // Called at posedge+1: drive this cycle's inputs, check, advance one clock.
  task automatic do_step(input step_t s, input logic [31:0] instr, input string tag);
    run            = s.run;
    bus.imem_ready = s.imem_ready;
    bus.imem_rdata = s.imem_ready ? instr : $urandom();
    bus.dmem_ready = s.dmem_ready;
    #3;
    chk(tag, "state", 32'(state), 32'(s.st));
    chk(tag, "imem_req", 32'(bus.imem_req), 32'(s.imem_req));
    chk(tag, "pc_write", 32'(pc_write), 32'(s.pc_write));
    chk(tag, "reg_write", 32'(reg_write), 32'(s.reg_write));
    chk(tag, "dmem_read", 32'(bus.dmem_read), 32'(s.dmem_read));
    chk(tag, "dmem_write", 32'(bus.dmem_write), 32'(s.dmem_write));
    if (s.st == 3'd3) begin
      chk(tag, "alu_src_imm", 32'(alu_src_imm), 32'(s.alu_src_imm));
      chk(tag, "alu_op", 32'(alu_op), 32'(s.alu_op));
    end
    if (s.pc_write)  chk(tag, "pc_sel", 32'(pc_sel), 32'(s.pc_sel));
    if (s.reg_write) chk(tag, "wb_sel", 32'(wb_sel), 32'(s.wb_sel));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_if_needed(input string tag);
    if (model_idle) begin
      do_step(blank(3'd0), 32'h0, {tag, "/idle"});
      model_idle = 1'b0;
    end
  endtask

  task automatic run_instr(input logic [31:0] instr, input int iwait, input int dwait,
                           input int drop, input string tag);
    bit all_run = 1'b1;
    idle_if_needed(tag);
    build(instr, iwait, dwait);
    if (drop >= 0 && drop < trace.size()) trace[drop].run = 1'b0;
    foreach (trace[i]) if (!trace[i].run) all_run = 1'b0;
    foreach (trace[i]) do_step(trace[i], instr, tag);
    exp_instret = exp_instret + 32'd1;
    model_idle  = !all_run;
    chk(tag, "ir", ir, instr);
    chk(tag, "instret", instret, exp_instret);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    run = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(tag, "state", 32'(state), 32'd0);
    chk(tag, "ir", ir, 32'd0);
    chk(tag, "instret", instret, 32'd0);
    chk(tag, "halted", 32'(halted), 32'd0);
    chk(tag, "bus_err", 32'(bus_err), 32'd0);
    chk(tag, "strobes", 32'({bus.imem_req, pc_write, reg_write, bus.dmem_read, bus.dmem_write}), 32'd0);
    rst = 1'b1;
    model_idle  = 1'b1;
    exp_instret = '0;
  endtask

  task automatic halt_steps(input string tag);
    step_t s;
    for (int k = 0; k < 4; k++) begin
      s = blank(3'd7);
      s.run = k[0];
      do_step(s, 32'h0, tag);
    end
  endtask

  function automatic logic [6:0] op_of(input int kind);
    case (kind)
      0: return K_R;
      1: return K_I;
      2: return K_LD;
      3: return K_ST;
      4: return K_BR;
      5: return K_JAL;
      default: return K_JR;
    endcase
  endfunction

  initial begin
    step_t       s;
    logic [31:0] instr;
    int          f3;
    int          drop;
    bus.imem_rdata = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;

    do_reset("reset");

    // Directed instructions.
    run_instr(32'h002081B3, 0, 0, -1, "add");
    run_instr(32'h0040A283, 0, 2, -1, "lw_wait3");
    alu_zero = 1'b1;
    run_instr(32'h00208463, 0, 0, -1, "beq_taken");
    alu_zero = 1'b0;
    run_instr(32'h00208463, 0, 0, -1, "beq_not_taken");
    run_instr(32'h000100E7, 0, 0, -1, "jalr");
    run_instr(32'h0040A283, 1, TMO, -1, "lw_ready_at_limit");
    run_instr(32'h0040A283, 0, 2, 3, "lw_run_pulse");
    idle_if_needed("after_pulse");
    model_idle = 1'b0;

    // Random instruction stream.
    for (int n = 0; n < 40; n++) begin
      instr = $urandom();
      instr[6:0] = op_of($urandom_range(6));
      if (instr[6:0] == K_BR) begin
        f3 = $urandom_range(5);
        instr[14:12] = 3'(f3 < 2 ? f3 : f3 + 2);
      end
      {alu_zero, alu_lt, alu_ltu} = 3'($urandom_range(7));
      drop = ($urandom_range(5) == 0) ? $urandom_range(12) : -1;
      run_instr(instr, $urandom_range(TMO), $urandom_range(TMO), drop, $sformatf("rnd%0d", n));
    end

    // Reset during WB suppresses the write-back and PC strobes.
    idle_if_needed("rst_mid");
    build(32'h002081B3, 0, 0);
    for (int i = 0; i < trace.size() - 1; i++) do_step(trace[i], 32'h002081B3, "rst_mid");
    run = 1'b1;
    rst = 1'b0;
    #3;
    chk("rst_mid", "reg_write", 32'(reg_write), 32'd0);
    chk("rst_mid", "pc_write", 32'(pc_write), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_mid", "state", 32'(state), 32'd0);
    model_idle  = 1'b1;
    exp_instret = '0;

    // Illegal opcode halts after DECODE; run has no effect.
    do_reset("reset_ill");
    idle_if_needed("illegal");
    s = blank(3'd1); s.imem_req = 1'b1; s.imem_ready = 1'b1;
    do_step(s, 32'h0000007F, "illegal");
    do_step(blank(3'd2), 32'h0, "illegal");
    halt_steps("illegal_halt");
    chk("illegal", "halted", 32'(halted), 32'd1);
    chk("illegal", "bus_err", 32'(bus_err), 32'd0);
    chk("illegal", "instret", instret, 32'd0);
    do_reset("reset_after_halt");

    // Undefined branch funct3 halts without retiring.
    idle_if_needed("bad_f3");
    s = blank(3'd1); s.imem_req = 1'b1; s.imem_ready = 1'b1;
    do_step(s, 32'h0020A063, "bad_f3");
    do_step(blank(3'd2), 32'h0, "bad_f3");
    s = blank(3'd3); s.alu_op = 2'd1;
    do_step(s, 32'h0, "bad_f3");
    halt_steps("bad_f3_halt");
    chk("bad_f3", "instret", instret, 32'd0);
    do_reset("reset_bf3");

    // Instruction fetch never answers.
    idle_if_needed("imem_tmo");
    for (int k = 0; k <= TMO; k++) begin
      s = blank(3'd1); s.imem_req = 1'b1;
      do_step(s, 32'h0, "imem_tmo");
    end
    halt_steps("imem_tmo_halt");
    chk("imem_tmo", "bus_err", 32'(bus_err), 32'd1);
    chk("imem_tmo", "instret", instret, 32'd0);
    do_reset("reset_itmo");

    // Data access never answers.
    idle_if_needed("dmem_tmo");
    s = blank(3'd1); s.imem_req = 1'b1; s.imem_ready = 1'b1;
    do_step(s, 32'h0040A283, "dmem_tmo");
    do_step(blank(3'd2), 32'h0, "dmem_tmo");
    s = blank(3'd3); s.alu_src_imm = 1'b1;
    do_step(s, 32'h0, "dmem_tmo");
    for (int k = 0; k <= TMO; k++) begin
      s = blank(3'd4); s.dmem_read = 1'b1;
      do_step(s, 32'h0, "dmem_tmo");
    end
    halt_steps("dmem_tmo_halt");
    chk("dmem_tmo", "bus_err", 32'(bus_err), 32'd1);
    chk("dmem_tmo", "instret", instret, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath. It fetches each instruction into an internal instruction register (IR) and drives the register-file/immediate unit through FETCH, DECODE, EXEC, MEM and WB states. It also asserts the register write strobe and the memory and PC control signals. It handshakes with instruction and data memories that may take multiple cycles, and halts on an illegal opcode or a memory timeout.

Parameters:
MEM_TIMEOUT, 255, max wait cycles for imem_ready/dmem_ready before bus error (1..65535)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low (active when 0)
run  in  1  level; allows leaving IDLE
imem_rdata  in  32  instruction from instruction memory
imem_ready  in  1  imem_rdata valid this cycle
dmem_ready  in  1  data access completes this cycle
alu_zero  in  1  ALU result == 0
alu_lt  in  1  signed rs1 < rs2
alu_ltu  in  1  unsigned rs1 < rs2
ir  out  32  latched instruction; feeds register file/immediate unit inst
imem_req  out  1  instruction fetch request
pc_write  out  1  PC update strobe
pc_sel  out  2  0 = pc+4, 1 = pc+imm (branch/jal), 2 = (rs1+imm)&~1 (jalr)
reg_write  out  1  register file write enable (1 cycle)
dmem_read  out  1  load request
dmem_write  out  1  store request
alu_src_imm  out  1  ALU B operand = imm32
alu_op  out  2  0 = add, 1 = sub/compare, 2 = funct-decoded
wb_sel  out  2  0 = ALU, 1 = memory, 2 = pc+4
state  out  3  current state encoding
halted  out  1  sticky halt
bus_err  out  1  sticky, set by timeout
instret  out  32  retired instruction count

Behaviour:
- Reset (rst == 0 at posedge): state = IDLE, ir = 0, instret = 0, halted = 0, bus_err = 0, timeout counter = 0. Every strobe output is 0 while in reset.
- Strobes are Moore outputs decoded from state and ir. They are 0 in IDLE and HALT.
- Encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 7.
- IDLE: go to FETCH when run == 1.
- FETCH: imem_req = 1.
  - On imem_ready: ir <= imem_rdata, go to DECODE.
- DECODE: one cycle for operand read. Go to EXEC if opcode ∈ {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111}, else HALT.
- EXEC: alu_src_imm = 1 for I/load/store/jalr. alu_op = 2 for R/I, 1 for branch, 0 otherwise.
  - Branch: taken per funct3 (000 = zero, 001 = !zero, 100 = lt, 101 = !lt, 110 = ltu, 111 = !ltu). Other funct3 → HALT.
  - Branch exit: pc_write = 1, pc_sel = taken ? 1 : 0, instret++, then FETCH if run, else IDLE.
  - Load/store go to MEM. R/I/jal/jalr go to WB.
- MEM: dmem_read (load) or dmem_write (store) held until dmem_ready.
  - On ready: load → WB. Store → pc_write = 1, pc_sel = 0, instret++, then FETCH/IDLE per run.
- WB: reg_write = 1 for exactly one cycle, with wb_sel = 1 for load, 2 for jal/jalr, 0 otherwise.
  - Same cycle: pc_write = 1, pc_sel = 1 for jal, 2 for jalr, 0 otherwise, instret++.
  - Next state FETCH if run, else IDLE.
- Register x0 write suppression stays in the register file. The controller still asserts reg_write when rd = 0.
- Timeout: the counter clears on entering FETCH/MEM and increments each waiting cycle.
  - If the counter reaches MEM_TIMEOUT with ready still 0, bus_err = 1 and state = HALT. No pc_write or instret change.
  - If ready arrives in the same cycle the counter hits MEM_TIMEOUT, ready wins.
- HALT: illegal opcode sets halted = 1. Exit only via reset; run is ignored.
- run deasserted mid-instruction: the current instruction completes, then IDLE.
- Reset mid-operation: abandons the instruction. No reg_write or pc_write on the reset cycle.
- instret wraps from 0xFFFFFFFF to 0.
- Zero-wait latency: branch 3 cycles, store 4, R/I/jal/jalr 4, load 5.

Decomposition:
- Shared package: opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR), state encodings, pc_sel/wb_sel/alu_op codes.
- One sub-module, branch_cond: combinational funct3 + flags → taken and valid.

Test Plan:
- Reset then run = 1, imem returns add x3,x1,x2 (0x002081B3) with imem_ready immediate → states 1,2,3,5; reg_write pulses once in cycle 4 with wb_sel = 0, pc_sel = 0; instret = 1.
- Load lw x5,4(x1) (0x0040A283), dmem_ready delayed 3 cycles → dmem_read held 3 cycles, then WB with wb_sel = 1; instret = 1.
- beq with alu_zero = 1 (0x00208463) → pc_write in EXEC with pc_sel = 1, no reg_write; repeat with alu_zero = 0 → pc_sel = 0.
- jalr x1,0(x2) (0x000100E7) → WB: reg_write = 1, wb_sel = 2, pc_sel = 2.
- Opcode 0x0000007F → HALT after DECODE, halted = 1, all strobes 0; run toggling has no effect until rst = 0.
- MEM_TIMEOUT = 4, imem_ready held 0 → bus_err = 1 and HALT after 4 wait cycles. Separately, a run = 0 pulse mid-load → load completes, state returns to IDLE (0).
